// File: rtl/pong_score_keeper.sv
// Purpose : Pong scoring stage. Edge-detects point events, keeps two BCD scores,
//           detects the win and runs a PLAY/HOLD/OVER state machine.
// Ports   : clk, rst (async active-low); point_p1/point_p2 level inputs, new_game
//           sync clear; BCD digit outputs, point_ack pulse, game_over, winner.
// Latency : one edge from an input rise to registered outputs; no input-to-output
//           combinational path. Point rises arriving during HOLD/OVER are dropped.
module pong_score_keeper #(
    parameter int WIN_SCORE   = 11,
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       point_p1,
    input  logic       point_p2,
    input  logic       new_game,
    output logic [3:0] p1_tens,
    output logic [3:0] p1_ones,
    output logic [3:0] p2_tens,
    output logic [3:0] p2_ones,
    output logic       point_ack,
    output logic       game_over,
    output logic [1:0] winner
);

    // HOLD_CYCLES-1 is the largest value the counter ever holds.
    localparam int               CNT_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [6:0]       WIN_VAL   = 7'(WIN_SCORE);

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    typedef enum logic [1:0] {
        ST_PLAY = 2'd0,
        ST_HOLD = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    // Two-digit BCD increment: {tens, ones}. Tens cannot overflow because the
    // game ends at WIN_SCORE <= 99.
    function automatic logic [7:0] bcd_inc(input logic [7:0] bcd);
        logic [7:0] res;
        if (bcd[3:0] == 4'd9) begin
            res = {bcd[7:4] + 4'd1, 4'd0};
        end else begin
            res = {bcd[7:4], bcd[3:0] + 4'd1};
        end
        return res;
    endfunction

    // Binary value of a two-digit BCD score, for the win compare.
    function automatic logic [6:0] bcd_value(input logic [7:0] bcd);
        return ({3'd0, bcd[7:4]} * 7'd10) + {3'd0, bcd[3:0]};
    endfunction

    state_t           state_q,     state_d;
    logic [CNT_W-1:0] hold_cnt_q,  hold_cnt_d;
    logic [7:0]       p1_bcd_q,    p1_bcd_d;
    logic [7:0]       p2_bcd_q,    p2_bcd_d;
    logic             p1_prev_q,   p1_prev_d;
    logic             p2_prev_q,   p2_prev_d;
    logic             point_ack_q, point_ack_d;
    logic             game_over_q, game_over_d;
    logic [1:0]       winner_q,    winner_d;

    logic       rise_p1;
    logic       rise_p2;
    logic [7:0] p1_next;
    logic [7:0] p2_next;

    assign rise_p1 = point_p1 & ~p1_prev_q;
    assign rise_p2 = point_p2 & ~p2_prev_q;
    assign p1_next = bcd_inc(p1_bcd_q);
    assign p2_next = bcd_inc(p2_bcd_q);

    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        p1_bcd_d    = p1_bcd_q;
        p2_bcd_d    = p2_bcd_q;
        // Edge history tracks the inputs every cycle, whatever the state, so a
        // level held through HOLD or OVER never looks like a fresh rise later.
        p1_prev_d   = point_p1;
        p2_prev_d   = point_p2;
        point_ack_d = 1'b0;
        game_over_d = game_over_q;
        winner_d    = winner_q;

        if (new_game) begin
            // Clear beats any rise in the same cycle; that rise is simply lost.
            state_d     = ST_PLAY;
            hold_cnt_d  = '0;
            p1_bcd_d    = 8'h00;
            p2_bcd_d    = 8'h00;
            game_over_d = 1'b0;
            winner_d    = WIN_NONE;
        end else begin
            case (state_q)
                ST_PLAY: begin
                    // Simultaneous rises are treated as a tie and discarded.
                    if (rise_p1 && !rise_p2) begin
                        p1_bcd_d    = p1_next;
                        point_ack_d = 1'b1;
                        if (bcd_value(p1_next) == WIN_VAL) begin
                            state_d     = ST_OVER;
                            game_over_d = 1'b1;
                            winner_d    = WIN_P1;
                        end else begin
                            state_d    = ST_HOLD;
                            hold_cnt_d = HOLD_LOAD;
                        end
                    end else if (rise_p2 && !rise_p1) begin
                        p2_bcd_d    = p2_next;
                        point_ack_d = 1'b1;
                        if (bcd_value(p2_next) == WIN_VAL) begin
                            state_d     = ST_OVER;
                            game_over_d = 1'b1;
                            winner_d    = WIN_P2;
                        end else begin
                            state_d    = ST_HOLD;
                            hold_cnt_d = HOLD_LOAD;
                        end
                    end
                end
                ST_HOLD: begin
                    // Loaded with HOLD_CYCLES-1, so leaving on the edge after it
                    // reads zero gives exactly HOLD_CYCLES lockout edges.
                    if (hold_cnt_q == '0) begin
                        state_d = ST_PLAY;
                    end else begin
                        hold_cnt_d = hold_cnt_q - 1'b1;
                    end
                end
                ST_OVER: begin
                    state_d = ST_OVER;
                end
                default: begin
                    state_d    = ST_PLAY;
                    hold_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_PLAY;
            hold_cnt_q  <= '0;
            p1_bcd_q    <= 8'h00;
            p2_bcd_q    <= 8'h00;
            p1_prev_q   <= 1'b0;
            p2_prev_q   <= 1'b0;
            point_ack_q <= 1'b0;
            game_over_q <= 1'b0;
            winner_q    <= WIN_NONE;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            p1_bcd_q    <= p1_bcd_d;
            p2_bcd_q    <= p2_bcd_d;
            p1_prev_q   <= p1_prev_d;
            p2_prev_q   <= p2_prev_d;
            point_ack_q <= point_ack_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
        end
    end

    assign p1_tens   = p1_bcd_q[7:4];
    assign p1_ones   = p1_bcd_q[3:0];
    assign p2_tens   = p2_bcd_q[7:4];
    assign p2_ones   = p2_bcd_q[3:0];
    assign point_ack = point_ack_q;
    assign game_over = game_over_q;
    assign winner    = winner_q;

endmodule

// File: tb/tb_pong_score_keeper.sv
// Bench for pong_score_keeper with WIN_SCORE=11, HOLD_CYCLES=4.
// Table of per-cycle vectors plus hand sequences; expectations pass through a
// scoreboard queue and are compared against outputs sampled 1 time unit after each edge.
module tb_pong_score_keeper;

    typedef struct packed {
        logic [3:0] p1t;
        logic [3:0] p1o;
        logic [3:0] p2t;
        logic [3:0] p2o;
        logic       ack;
        logic       go;
        logic [1:0] win;
    } exp_t;

    typedef struct {
        logic p1;
        logic p2;
        logic ng;
        exp_t e;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       point_p1 = 1'b0;
    logic       point_p2 = 1'b0;
    logic       new_game = 1'b0;
    logic [3:0] p1_tens, p1_ones, p2_tens, p2_ones;
    logic       point_ack, game_over;
    logic [1:0] winner;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   ack_seen = 0;
    exp_t sb_q[$];
    vec_t vecs[$];

    pong_score_keeper #(.WIN_SCORE(11), .HOLD_CYCLES(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .point_p1 (point_p1),
        .point_p2 (point_p2),
        .new_game (new_game),
        .p1_tens  (p1_tens),
        .p1_ones  (p1_ones),
        .p2_tens  (p2_tens),
        .p2_ones  (p2_ones),
        .point_ack(point_ack),
        .game_over(game_over),
        .winner   (winner)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input int p1, input int p2, input logic ack,
                                input logic go, input logic [1:0] win);
        exp_t e;
        e.p1t = 4'(p1 / 10);
        e.p1o = 4'(p1 % 10);
        e.p2t = 4'(p2 / 10);
        e.p2o = 4'(p2 % 10);
        e.ack = ack;
        e.go  = go;
        e.win = win;
        return e;
    endfunction

    function automatic exp_t dut_out();
        exp_t a;
        a = {p1_tens, p1_ones, p2_tens, p2_ones, point_ack, game_over, winner};
        return a;
    endfunction

    task automatic add_vec(input logic p1, input logic p2, input logic ng, input exp_t e);
        vec_t v;
        v.p1 = p1;
        v.p2 = p2;
        v.ng = ng;
        v.e  = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input exp_t act, input exp_t exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got p1=%h%h p2=%h%h ack=%b go=%b win=%b, expected p1=%h%h p2=%h%h ack=%b go=%b win=%b",
                     name, act.p1t, act.p1o, act.p2t, act.p2o, act.ack, act.go, act.win,
                     exp.p1t, exp.p1o, exp.p2t, exp.p2o, exp.ack, exp.go, exp.win);
        end
    endtask

    // Drive one cycle of inputs, queue its expected result, pop and compare after the edge.
    task automatic step(input string name, input logic p1, input logic p2, input logic ng,
                        input exp_t e);
        exp_t ex;
        @(negedge clk);
        point_p1 = p1;
        point_p2 = p2;
        new_game = ng;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (point_ack === 1'b1) ack_seen++;
        if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            ex = sb_q.pop_front();
            check(name, dut_out(), ex);
        end
    endtask

    task automatic gap(input string name, input int n, input exp_t e);
        for (int g = 0; g < n; g++) step(name, 1'b0, 1'b0, 1'b0, e);
    endtask

    initial begin
        exp_t ex;

        // Reset state while rst is held low.
        #2;
        check("reset_state", dut_out(), mk(0, 0, 0, 0, 2'b00));
        @(negedge clk);
        rst = 1'b1;

        // ---- Table: lockout boundary, held-high input, simultaneous rises, new_game ----
        add_vec(1, 0, 0, mk(1, 0, 1, 0, 2'b00)); // rise accepted at k
        add_vec(0, 0, 0, mk(1, 0, 0, 0, 2'b00)); // k+1
        add_vec(1, 0, 0, mk(1, 0, 0, 0, 2'b00)); // k+2 pulse ignored
        add_vec(0, 0, 0, mk(1, 0, 0, 0, 2'b00)); // k+3
        add_vec(1, 0, 0, mk(1, 0, 0, 0, 2'b00)); // k+4 pulse ignored (last HOLD edge)
        add_vec(0, 0, 0, mk(1, 0, 0, 0, 2'b00)); // k+5 PLAY, no rise
        add_vec(1, 0, 0, mk(2, 0, 1, 0, 2'b00)); // accepted
        add_vec(0, 0, 0, mk(2, 0, 0, 0, 2'b00));
        add_vec(1, 0, 0, mk(2, 0, 0, 0, 2'b00)); // +2 ignored
        add_vec(0, 0, 0, mk(2, 0, 0, 0, 2'b00));
        add_vec(0, 0, 0, mk(2, 0, 0, 0, 2'b00));
        add_vec(1, 0, 0, mk(3, 0, 1, 0, 2'b00)); // +5 accepted exactly
        add_vec(1, 0, 0, mk(3, 0, 0, 0, 2'b00)); // held high through HOLD
        add_vec(1, 0, 0, mk(3, 0, 0, 0, 2'b00));
        add_vec(1, 0, 0, mk(3, 0, 0, 0, 2'b00));
        add_vec(1, 0, 0, mk(3, 0, 0, 0, 2'b00));
        add_vec(1, 0, 0, mk(3, 0, 0, 0, 2'b00)); // PLAY but no new rise
        add_vec(0, 0, 0, mk(3, 0, 0, 0, 2'b00));
        add_vec(1, 0, 0, mk(4, 0, 1, 0, 2'b00)); // fresh rise scores
        add_vec(0, 0, 0, mk(4, 0, 0, 0, 2'b00));
        add_vec(0, 0, 0, mk(4, 0, 0, 0, 2'b00));
        add_vec(0, 0, 0, mk(4, 0, 0, 0, 2'b00));
        add_vec(0, 0, 0, mk(4, 0, 0, 0, 2'b00));
        add_vec(1, 1, 0, mk(4, 0, 0, 0, 2'b00)); // both rise: no score
        add_vec(0, 0, 0, mk(4, 0, 0, 0, 2'b00));
        add_vec(1, 1, 1, mk(0, 0, 0, 0, 2'b00)); // both rise with new_game: clear
        add_vec(0, 0, 0, mk(0, 0, 0, 0, 2'b00));
        add_vec(0, 1, 0, mk(0, 1, 1, 0, 2'b00)); // play resumes
        add_vec(0, 0, 1, mk(0, 0, 0, 0, 2'b00)); // new_game during HOLD
        add_vec(1, 0, 0, mk(1, 0, 1, 0, 2'b00)); // PLAY right after clear
        add_vec(0, 0, 1, mk(0, 0, 0, 0, 2'b00));
        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i].p1, vecs[i].p2, vecs[i].ng, vecs[i].e);
        end

        // ---- Ten p2 points: ones roll 9 -> 0 with tens carry ----
        ack_seen = 0;
        for (int i = 1; i <= 10; i++) begin
            step($sformatf("p2_pt%0d", i), 1'b0, 1'b1, 1'b0, mk(0, i, 1, 0, 2'b00));
            gap("p2_gap", 4, mk(0, i, 0, 0, 2'b00));
        end
        n_checks++;
        if (ack_seen == 10) n_pass++;
        else $display("FAIL p2_ack_count: got %0d expected 10", ack_seen);
        step("p2_clear", 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 0, 2'b00));

        // ---- Player 1 wins at 11 ----
        for (int i = 1; i <= 11; i++) begin
            step($sformatf("p1_pt%0d", i), 1'b1, 1'b0, 1'b0,
                 mk(i, 0, 1, (i == 11), (i == 11) ? 2'b01 : 2'b00));
            if (i < 11) gap("p1_gap", 4, mk(i, 0, 0, 0, 2'b00));
        end
        for (int j = 0; j < 3; j++) begin
            step("over_p1", 1'b0, 1'b0, 1'b0, mk(11, 0, 0, 1, 2'b01));
            step("over_p1", 1'b1, 1'b0, 1'b0, mk(11, 0, 0, 1, 2'b01));
            step("over_p2", 1'b0, 1'b1, 1'b0, mk(11, 0, 0, 1, 2'b01));
        end
        step("over_idle", 1'b0, 1'b0, 1'b0, mk(11, 0, 0, 1, 2'b01));
        step("over_clear", 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 0, 2'b00));
        step("resume_p2", 1'b0, 1'b1, 1'b0, mk(0, 1, 1, 0, 2'b00));
        gap("resume_gap", 4, mk(0, 1, 0, 0, 2'b00));
        step("resume_clear", 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 0, 2'b00));

        // ---- Async reset mid-HOLD with p1=3, input held high through release ----
        for (int i = 1; i <= 3; i++) begin
            step($sformatf("rst_pt%0d", i), 1'b1, 1'b0, 1'b0, mk(i, 0, 1, 0, 2'b00));
            if (i < 3) gap("rst_gap", 4, mk(i, 0, 0, 0, 2'b00));
        end
        step("rst_hold", 1'b0, 1'b0, 1'b0, mk(3, 0, 0, 0, 2'b00));
        #2;
        point_p1 = 1'b1;
        rst      = 1'b0;
        sb_q.push_back(mk(0, 0, 0, 0, 2'b00));
        #1;
        ex = sb_q.pop_front();
        check("rst_async", dut_out(), ex);
        @(posedge clk);
        #2;
        rst = 1'b1;
        step("rst_release_pt", 1'b1, 1'b0, 1'b0, mk(1, 0, 1, 0, 2'b00));
        step("rst_release_held", 1'b1, 1'b0, 1'b0, mk(1, 0, 0, 0, 2'b00));
        step("rst_release_low", 1'b0, 1'b0, 1'b0, mk(1, 0, 0, 0, 2'b00));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pong_score_keeper.md
# pong_score_keeper

Scoring stage for the Pong game. It takes point events from the ball/collision logic and keeps two decimal (BCD) scores. It detects the win condition and runs a small play/hold/over state machine. Its four 4-bit digit outputs drive the per-digit seven-segment decoders directly; each digit stays in 0–9, so no hex glyphs appear.

## Interface
- WIN_SCORE, 11: score that ends the game. Legal range 1–99.
- HOLD_CYCLES, 4: lockout cycles after an accepted point, during which new point edges are ignored. Must be ≥1.
- clk  input  1  system clock; all state changes on its rising edge
- rst  input  1  asynchronous, active-low reset
- point_p1  input  1  level from ball logic; a rising edge scores one point for player 1
- point_p2  input  1  level from ball logic; a rising edge scores one point for player 2
- new_game  input  1  synchronous clear and restart; sampled every cycle
- p1_tens, p1_ones  output  4 each  player 1 score in BCD, each 0–9
- p2_tens, p2_ones  output  4 each  player 2 score in BCD, each 0–9
- point_ack  output  1  one-cycle pulse when a point is accepted
- game_over  output  1  high while in OVER
- winner  output  2  00 none, 01 player 1, 10 player 2; 11 never driven

## Operation
- Reset (rst=0, asynchronous):
  - all digits 0, point_ack=0, game_over=0, winner=00, state=PLAY, hold counter 0
  - edge-detect registers cleared to 0, so an input already high when rst releases counts as a rising edge
- Edge detection: each input has a previous-value register that updates every cycle in every state. A rise is input=1 with previous=0.
- States:
  - PLAY:
    - a rise on exactly one input increments that player's score, pulses point_ack and goes to HOLD (or to OVER if the new score equals WIN_SCORE)
    - rises on both inputs in the same cycle: no score change, no point_ack, remain in PLAY
  - HOLD: counter loads HOLD_CYCLES−1 on entry and decrements each cycle. All rises are ignored. Return to PLAY on the cycle after the counter reads 0, so the lockout lasts exactly HOLD_CYCLES cycles.
  - OVER: scores, winner and game_over hold. Point inputs are ignored.
- new_game=1 in any state:
  - clears all digits, winner=00, game_over=0, hold counter; next state PLAY
  - overrides any point rise in the same cycle; that rise is lost
- BCD increment: ones 9→0 with tens+1; otherwise ones+1. Tens never exceeds 9, because WIN_SCORE ≤ 99 stops play first.
- Win compare: the incremented value, tens×10+ones, is compared with WIN_SCORE in the same cycle as the increment.
- Outputs are registered only; there is no combinational path from inputs to outputs.

## Timing
- Point latency: a rise present before clock edge k updates the digits and point_ack immediately after edge k. point_ack is high for exactly one cycle.
- game_over and winner assert after the same edge k that applies the winning point.
- HOLD spans edges k+1 … k+HOLD_CYCLES. A rise sampled at edge k+HOLD_CYCLES+1 is accepted.
- An input held high through HOLD does not score again after HOLD ends; it must fall and rise again.
- new_game takes effect after one edge. Outputs read 0/00 from the next cycle.
- rst asserted mid-HOLD or mid-OVER forces the reset values immediately, without waiting for a clock edge.

## Test plan
- Reset then a single point_p1 rise:
  - p1_ones=1 and point_ack=1 for one cycle, one edge after the rise
  - all other digits stay 0
- With HOLD_CYCLES=4, p1 rise, then further p1 pulses at +2 and +4 cycles:
  - the +2 and +4 pulses are ignored
  - a pulse at +5 is accepted, giving p1_ones=2
- Ten p2 points spaced beyond the lockout:
  - digits step through 0…9, then p2_tens=1, p2_ones=0
  - point_ack count equals 10
- WIN_SCORE=11, p1 reaches 11:
  - game_over=1, winner=01 after the 11th point
  - later p1/p2 pulses leave 1/1 and 0/0 unchanged
  - new_game returns everything to 0, winner=00, and play resumes
- point_p1 and point_p2 rise on the same edge: no score change and no point_ack. The same cycle with new_game=1 also clears everything.
- rst pulled low mid-HOLD with p1=3:
  - outputs read 0 before the next clock edge
  - an input held high through the release of rst scores one point on the first edge
